// File: rtl/calr_debin.sv
// calr_debin -- serial debinarizer for HEVC coeff_abs_level_remaining.
//
// Consumes one bin per accepted cycle: a unary prefix of 1-bins ended by a
// 0-bin, then a fixed-length suffix (MSB first) whose length depends on the
// prefix and the Rice parameter. It reconstructs the value and the number of
// bins consumed.
//
// Optional feature: define CALR_DEBIN_ERR_EN to flag a prefix of MAX_PREFIX
// consecutive 1-bins as malformed (done with err=1). When it is undefined, err
// is tied low and q saturates at MAX_PREFIX while decoding continues.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin one symbol (honoured only in IDLE)
//   cRiceParam : Rice parameter, clamped to 4, sampled on start
//   bin_valid  : bin_in carries a bin
//   bin_in     : serial bin
//   bin_ready  : decoder accepts a bin this cycle (PREFIX/SUFFIX only)
//   CALR       : decoded value, held until the next start
//   bin_length : bins consumed for the symbol, held until the next start
//   done       : one-cycle result pulse
//   err        : malformed prefix, valid with done
module calr_debin #(
  parameter int VALUE_WIDTH = 16,
  parameter int BIN_WIDTH   = 16,
  parameter int MAX_PREFIX  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             cRiceParam,
  input  logic                   bin_valid,
  input  logic                   bin_in,
  output logic                   bin_ready,
  output logic [VALUE_WIDTH-1:0] CALR,
  output logic [BIN_WIDTH-1:0]   bin_length,
  output logic                   done,
  output logic                   err
);

  localparam int CW = VALUE_WIDTH + 8;             // internal arithmetic width
  localparam int QW = $clog2(MAX_PREFIX + 1);      // holds q up to MAX_PREFIX
  localparam int KW = $clog2(MAX_PREFIX + 2) + 1;  // holds k up to MAX_PREFIX+1

  typedef enum logic [1:0] {IDLE, PREFIX, SUFFIX, DONE} state_t;

  state_t                 r_state;
  logic [2:0]             r_r;
  logic [QW-1:0]          r_q;
  logic [KW-1:0]          r_k;
  logic [CW-1:0]          r_base;
  logic [CW-1:0]          r_suffix;
  logic [VALUE_WIDTH-1:0] r_calr;
  logic [BIN_WIDTH-1:0]   r_cnt;
  logic                   r_bin_ready;
  logic                   r_done;

  logic                   w_acc;
  logic [QW-1:0]          w_e;
  logic [3:0]             w_r1;
  logic [CW-1:0]          w_base_short;
  logic [CW-1:0]          w_base_long;
  logic [KW-1:0]          w_k_long;
  logic [CW-1:0]          w_suffix_nxt;

  always_comb begin
    w_acc        = bin_valid & r_bin_ready;
    w_e          = r_q - QW'(4);
    w_r1         = {1'b0, r_r} + 4'd1;
    // q < 4: plain Rice prefix
    w_base_short = CW'(r_q) << r_r;
    // q >= 4: Exp-Golomb escape, offset past the Rice range
    w_base_long  = (CW'(4) << r_r) + (((CW'(1) << w_e) - CW'(1)) << w_r1);
    w_k_long     = KW'(r_r) + KW'(1) + KW'(w_e);
    w_suffix_nxt = (r_suffix << 1) | CW'(bin_in);
  end

`ifdef CALR_DEBIN_ERR_EN
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_r         <= '0;
      r_q         <= '0;
      r_k         <= '0;
      r_base      <= '0;
      r_suffix    <= '0;
      r_calr      <= '0;
      r_cnt       <= '0;
      r_bin_ready <= 1'b0;
      r_done      <= 1'b0;
`ifdef CALR_DEBIN_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_r         <= (cRiceParam > 4'd4) ? 3'd4 : cRiceParam[2:0];
          r_q         <= '0;
          r_k         <= '0;
          r_base      <= '0;
          r_suffix    <= '0;
          r_calr      <= '0;
          r_cnt       <= '0;
          r_bin_ready <= 1'b1;
`ifdef CALR_DEBIN_ERR_EN
          r_err       <= 1'b0;
`endif
          r_state     <= PREFIX;
        end
        PREFIX: if (w_acc) begin
          r_cnt <= r_cnt + BIN_WIDTH'(1);
          if (bin_in) begin
`ifdef CALR_DEBIN_ERR_EN
            r_q <= r_q + QW'(1);
            if (r_q == QW'(MAX_PREFIX - 1)) begin
              r_err       <= 1'b1;
              r_calr      <= '0;
              r_bin_ready <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end
`else
            // saturate; extra 1-bins still count in bin_length
            if (r_q != QW'(MAX_PREFIX)) r_q <= r_q + QW'(1);
`endif
          end else if (r_q < QW'(4)) begin
            r_base <= w_base_short;
            r_k    <= KW'(r_r);
            if (r_r == 3'd0) begin
              // no suffix bins: value is the prefix alone
              r_calr      <= VALUE_WIDTH'(w_base_short);
              r_bin_ready <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= SUFFIX;
            end
          end else begin
            r_base  <= w_base_long;
            r_k     <= w_k_long;
            r_state <= SUFFIX;
          end
        end
        SUFFIX: if (w_acc) begin
          r_cnt    <= r_cnt + BIN_WIDTH'(1);
          r_suffix <= w_suffix_nxt;
          r_k      <= r_k - KW'(1);
          if (r_k == KW'(1)) begin
            r_calr      <= VALUE_WIDTH'(r_base + w_suffix_nxt);
            r_bin_ready <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bin_ready  = r_bin_ready;
  assign done       = r_done;
  assign CALR       = r_calr;
  assign bin_length = r_cnt;

endmodule

// File: tb/tb_calr_debin.sv
// Directed bench for calr_debin: reset values, Rice and escape decodes,
// parameter clamp, bin_valid gaps, long-prefix handling and mid-symbol reset.
module tb_calr_debin;
  logic        clk = 1'b0;
  logic        rst, start, bin_valid, bin_in;
  logic [3:0]  cRiceParam;
  logic        bin_ready, done, err;
  logic [15:0] CALR;
  logic [15:0] bin_length;
  int          total = 0;
  int          bad   = 0;

  calr_debin #(.VALUE_WIDTH(16), .BIN_WIDTH(16), .MAX_PREFIX(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cRiceParam(cRiceParam),
    .bin_valid(bin_valid), .bin_in(bin_in), .bin_ready(bin_ready),
    .CALR(CALR), .bin_length(bin_length), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start pulse overlaps a valid 1-bin; that bin must not be consumed.
  task automatic start_sym(input logic [3:0] rp);
    @(negedge clk);
    start = 1'b1; cRiceParam = rp; bin_valid = 1'b1; bin_in = 1'b1;
    @(negedge clk);
    start = 1'b0; bin_valid = 1'b0; cRiceParam = 4'd0;
  endtask

  task automatic feed(input string tag, input string bits, input bit gaps);
    for (int i = 0; i < bits.len(); i++) begin
      if (gaps) begin
        bin_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      chk({tag, ".ready"}, 32'(bin_ready), 32'd1);
      bin_valid = 1'b1;
      bin_in    = (bits[i] == "1");
      @(negedge clk);
    end
    bin_valid = 1'b0;
  endtask

  // Called at the negedge following the final accepted bin.
  task automatic check_done(input string tag, input int ecalr, input int elen, input logic eerr);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".calr"}, 32'(CALR), 32'(ecalr));
    chk({tag, ".len"},  32'(bin_length), 32'(elen));
    chk({tag, ".err"},  32'(err), 32'(eerr));
    start = 1'b1; cRiceParam = 4'd2;   // must be ignored in DONE
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".pulse"}, 32'(done), 32'd0);
    chk({tag, ".idle"},  32'(bin_ready), 32'd0);
    chk({tag, ".hold"},  32'(CALR), 32'(ecalr));
    chk({tag, ".holdl"}, 32'(bin_length), 32'(elen));
  endtask

  task automatic run(input string tag, input logic [3:0] rp, input string bits,
                     input bit gaps, input int ecalr, input int elen);
    start_sym(rp);
    feed(tag, bits, gaps);
    check_done(tag, ecalr, elen, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin_valid = 1'b0; bin_in = 1'b0; cRiceParam = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(bin_ready), 32'd0);
    chk("rst.done",  32'(done), 32'd0);
    chk("rst.err",   32'(err), 32'd0);
    chk("rst.calr",  32'(CALR), 32'd0);
    chk("rst.len",   32'(bin_length), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("r0_0",     4'd0, "0",      1'b0, 0, 1);
    run("r0_esc",   4'd0, "111100", 1'b0, 4, 6);
    run("r0_1110",  4'd0, "1110",   1'b0, 3, 4);
    run("r1_1101",  4'd1, "1101",   1'b0, 5, 4);
    run("r6_clamp", 4'd6, "00000",  1'b0, 0, 5);
    run("r0_77",    4'd0, "1111111110001011", 1'b0, 77, 16);
    run("r0_77gap", 4'd0, "1111111110001011", 1'b1, 77, 16);

    // 16 consecutive 1-bins
    start_sym(4'd0);
    feed("long", "1111111111111111", 1'b0);
`ifdef CALR_DEBIN_ERR_EN
    check_done("long_err", 0, 16, 1'b1);
`else
    repeat (3) begin
      chk("long.nodone", 32'(done), 32'd0);
      chk("long.wait",   32'(bin_ready), 32'd1);
      @(negedge clk);
    end
    // one more 1 (q saturated at 16), then 0: e=12, k=13, base=8194
    feed("long2", "10", 1'b0);
    chk("long.sfx", 32'(done), 32'd0);
    feed("long3", "0000000000000", 1'b0);
    check_done("long_sat", 8194, 31, 1'b0);
`endif

    // reset mid-prefix abandons the symbol
    start_sym(4'd0);
    feed("mid", "111", 1'b0);
    chk("mid.len3", 32'(bin_length), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.ready", 32'(bin_ready), 32'd0);
    chk("mid.len",   32'(bin_length), 32'd0);
    repeat (3) begin
      chk("mid.nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    run("post_rst", 4'd0, "0", 1'b0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog: a hung handshake still reaches the summary line
  initial begin
    #200000;
    total++; bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
